// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared defaults, state encoding and id-width helper for the FIFO read arbiter
package fifo_arb_pkg;

   localparam int NREQ_DEF = 4;
   localparam int DW_DEF   = 8;
   localparam int LW_DEF   = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_e;

   // Index width for n consumers; never below one bit so a single-consumer build still has a port
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker, first set request above rr_ptr with wrap
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int IW   = id_width(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   rr_ptr,
   output logic            any,
   output logic [NREQ-1:0] winner,
   output logic [IW-1:0]   win_idx
);

   logic [IW-1:0] cand;

   // Scan rr_ptr+1 .. rr_ptr+NREQ so the last-served consumer is considered last
   always_comb begin
      any     = 1'b0;
      winner  = '0;
      win_idx = '0;
      cand    = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = IW'((int'(rr_ptr) + k) % NREQ);
         if (!any && req[cand]) begin
            any          = 1'b1;
            winner[cand] = 1'b1;
            win_idx      = cand;
         end
      end
   end

endmodule

// File: rtl/fifo_rd_burst_arbiter.sv
// rtl/fifo_rd_burst_arbiter.sv - round-robin burst scheduler sharing one async-FIFO read port
module fifo_rd_burst_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int DW   = DW_DEF,
   parameter int LW   = LW_DEF,
   parameter int IW   = id_width(NREQ)
) (
   input  logic             clk,
   input  logic             rresetn,
   input  logic [NREQ-1:0]  req,
   input  logic [NREQ*LW-1:0] req_len,
   input  logic             empty,
   input  logic [DW-1:0]    fifo_rdata,
   output logic             rinc,
   output logic [NREQ-1:0]  grant,
   output logic             out_valid,
   output logic [DW-1:0]    out_data,
   output logic [IW-1:0]    out_id,
   output logic [NREQ-1:0]  done
);

   arb_state_e    state, state_nxt;
   logic [LW-1:0] cnt;
   logic [IW-1:0] owner;
   logic [IW-1:0] rr_ptr;
   logic          accept;
   logic          last_beat;

   logic            pick_any;
   logic [NREQ-1:0] pick_onehot;
   logic [IW-1:0]   pick_idx;
   logic [LW-1:0]   len_arr [NREQ];

   for (genvar i = 0; i < NREQ; i++) begin : g_len
      assign len_arr[i] = req_len[i*LW +: LW];
   end

   rr_pick #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_rr_pick (
      .req     (req),
      .rr_ptr  (rr_ptr),
      .any     (pick_any),
      .winner  (pick_onehot),
      .win_idx (pick_idx)
   );

   // Next state and pop strobe; a pop only ever happens in BURST with data present
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      last_beat = 1'b0;
      case (state)
         IDLE: begin
            if (pick_any) begin
               state_nxt = BURST;
            end
         end
         BURST: begin
            accept    = ~empty;
            last_beat = ~empty && (cnt == '0);
            if (last_beat) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign rinc = accept;

   // State register
   always_ff @(posedge clk or negedge rresetn) begin
      if (!rresetn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Burst ownership: latch winner and length at grant, count beats, hand priority on completion
   always_ff @(posedge clk or negedge rresetn) begin
      if (!rresetn) begin
         grant  <= '0;
         owner  <= '0;
         cnt    <= '0;
         rr_ptr <= IW'(NREQ - 1);
      end else if (state == IDLE) begin
         if (pick_any) begin
            grant <= pick_onehot;
            owner <= pick_idx;
            cnt   <= len_arr[pick_idx];
         end
      end else if (accept) begin
         if (last_beat) begin
            grant  <= '0;
            rr_ptr <= owner;
         end else begin
            cnt <= cnt - LW'(1);
         end
      end
   end

   // Registered read return; done rides with the final word
   always_ff @(posedge clk or negedge rresetn) begin
      if (!rresetn) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_id    <= '0;
         done      <= '0;
      end else begin
         out_valid <= accept;
         done      <= '0;
         if (accept) begin
            out_data <= fifo_rdata;
            out_id   <= owner;
         end
         if (last_beat) begin
            done[owner] <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fifo_rd_burst_arbiter.sv
// tb/tb_fifo_rd_burst_arbiter.sv - directed self-checking bench for fifo_rd_burst_arbiter
module tb_fifo_rd_burst_arbiter;

   logic        clk;
   logic        rresetn;
   logic [3:0]  req;
   logic [15:0] req_len;
   logic        empty;
   logic [7:0]  fifo_rdata;
   logic        rinc;
   logic [3:0]  grant;
   logic        out_valid;
   logic [7:0]  out_data;
   logic [1:0]  out_id;
   logic [3:0]  done;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [7:0]  q [$];
   logic        stall;
   logic        pop_seen;
   int          pop_cnt = 0;

   fifo_rd_burst_arbiter dut (
      .clk        (clk),
      .rresetn    (rresetn),
      .req        (req),
      .req_len    (req_len),
      .empty      (empty),
      .fifo_rdata (fifo_rdata),
      .rinc       (rinc),
      .grant      (grant),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_id     (out_id),
      .done       (done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) pop_seen <= rinc;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One cycle: FIFO model pops what was accepted at the last edge, then presents its head
   task automatic step();
      @(negedge clk);
      if (pop_seen === 1'b1) begin
         if (q.size() > 0) void'(q.pop_front());
         pop_cnt++;
      end
      empty      = stall || (q.size() == 0);
      fifo_rdata = (q.size() > 0) ? q[0] : 8'h00;
      #1;
   endtask

   task automatic obs(input string tag, input logic [3:0] g, input logic r,
                      input logic v, input logic [7:0] d, input logic [3:0] dn);
      check($sformatf("%s.grant", tag), 32'(grant), 32'(g));
      check($sformatf("%s.rinc", tag), 32'(rinc), 32'(r));
      check($sformatf("%s.out_valid", tag), 32'(out_valid), 32'(v));
      if (v) check($sformatf("%s.out_data", tag), 32'(out_data), 32'(d));
      check($sformatf("%s.done", tag), 32'(done), 32'(dn));
   endtask

   int nw;
   int done_seen;
   int p0;

   initial begin
      rresetn    = 1'b0;
      req        = 4'b1111;
      req_len    = 16'h0000;
      stall      = 1'b0;
      empty      = 1'b1;
      fifo_rdata = 8'h00;
      q.push_back(8'hA0);

      // Reset holds everything quiet even with all requests up
      repeat (3) step();
      obs("rst", 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000);
      check("rst.out_data", 32'(out_data), 32'h0);
      check("rst.out_id", 32'(out_id), 32'h0);
      rresetn = 1'b1;
      step();
      obs("rst.g0", 4'b0001, 1'b1, 1'b0, 8'h00, 4'b0000);
      req = 4'b0000;
      step();
      obs("rst.b0", 4'b0000, 1'b0, 1'b1, 8'hA0, 4'b0001);
      check("rst.b0.id", 32'(out_id), 32'd0);

      // Single 4-word burst for consumer 2
      q.delete();
      for (int i = 0; i < 4; i++) q.push_back(8'(8'h10 + i));
      req = 4'b0100;
      req_len[11:8] = 4'd3;
      step();
      obs("sb.1", 4'b0100, 1'b1, 1'b0, 8'h00, 4'b0000);
      req = 4'b0000;
      step();
      obs("sb.2", 4'b0100, 1'b1, 1'b1, 8'h10, 4'b0000);
      check("sb.2.id", 32'(out_id), 32'd2);
      step();
      obs("sb.3", 4'b0100, 1'b1, 1'b1, 8'h11, 4'b0000);
      step();
      obs("sb.4", 4'b0100, 1'b1, 1'b1, 8'h12, 4'b0000);
      step();
      obs("sb.5", 4'b0000, 1'b0, 1'b1, 8'h13, 4'b0100);
      check("sb.5.id", 32'(out_id), 32'd2);

      // Round-robin over 0,1,3 from a fresh reset, 1-word bursts
      q.delete();
      for (int i = 0; i < 6; i++) q.push_back(8'(8'h20 + i));
      req_len = 16'h0000;
      req     = 4'b1011;
      rresetn = 1'b0;
      step();
      rresetn = 1'b1;
      for (int i = 0; i < 6; i++) begin
         automatic int id = (i % 3 == 2) ? 3 : (i % 3);
         step();
         obs($sformatf("rr%0d.g", i), 4'(1 << id), 1'b1, 1'b0, 8'h00, 4'b0000);
         step();
         obs($sformatf("rr%0d.d", i), 4'b0000, 1'b0, 1'b1, 8'(8'h20 + i), 4'(1 << id));
         check($sformatf("rr%0d.id", i), 32'(out_id), 32'(id));
      end
      req = 4'b0000;

      // Consumer 1, 4 words, FIFO runs dry for 5 cycles after word 2
      step();
      q.delete();
      for (int i = 0; i < 4; i++) q.push_back(8'(8'h30 + i));
      req = 4'b0010;
      req_len[7:4] = 4'd3;
      step();
      obs("st.1", 4'b0010, 1'b1, 1'b0, 8'h00, 4'b0000);
      req = 4'b0000;
      step();
      obs("st.2", 4'b0010, 1'b1, 1'b1, 8'h30, 4'b0000);
      stall = 1'b1;
      step();
      obs("st.3", 4'b0010, 1'b0, 1'b1, 8'h31, 4'b0000);
      for (int i = 0; i < 4; i++) begin
         step();
         obs($sformatf("st.hold%0d", i), 4'b0010, 1'b0, 1'b0, 8'h00, 4'b0000);
      end
      stall = 1'b0;
      step();
      obs("st.resume", 4'b0010, 1'b1, 1'b0, 8'h00, 4'b0000);
      step();
      obs("st.w3", 4'b0010, 1'b1, 1'b1, 8'h32, 4'b0000);
      step();
      obs("st.w4", 4'b0000, 1'b0, 1'b1, 8'h33, 4'b0010);
      check("st.w4.id", 32'(out_id), 32'd1);

      // Consumer 3, maximum length: exactly 16 pops with a 17th word waiting
      step();
      q.delete();
      for (int i = 0; i < 17; i++) q.push_back(8'(8'h40 + i));
      req = 4'b1000;
      req_len[15:12] = 4'hF;
      p0        = pop_cnt;
      nw        = 0;
      done_seen = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (i == 0) req = 4'b0000;
         if (out_valid) begin
            check($sformatf("max.data%0d", nw), 32'(out_data), 32'(8'h40 + nw));
            check($sformatf("max.id%0d", nw), 32'(out_id), 32'd3);
            nw++;
         end
         if (done != 4'b0000) begin
            done_seen++;
            check("max.done", 32'(done), 32'b1000);
            check("max.done_pos", 32'(nw), 32'd16);
         end
      end
      check("max.words", 32'(nw), 32'd16);
      check("max.pops", 32'(pop_cnt - p0), 32'd16);
      check("max.left", 32'(q.size()), 32'd1);
      check("max.done_cnt", 32'(done_seen), 32'd1);
      check("max.grant_end", 32'(grant), 32'h0);

      // Reset during word 3 of an 8-word burst for consumer 0
      q.delete();
      for (int i = 0; i < 8; i++) q.push_back(8'(8'h50 + i));
      req = 4'b0001;
      req_len = 16'h0007;
      step();
      obs("rm.1", 4'b0001, 1'b1, 1'b0, 8'h00, 4'b0000);
      req = 4'b0000;
      step();
      obs("rm.2", 4'b0001, 1'b1, 1'b1, 8'h50, 4'b0000);
      step();
      obs("rm.3", 4'b0001, 1'b1, 1'b1, 8'h51, 4'b0000);
      rresetn = 1'b0;
      #1;
      obs("rm.async", 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000);
      p0 = pop_cnt;
      step();
      step();
      check("rm.pops", 32'(pop_cnt - p0), 32'd0);
      check("rm.left", 32'(q.size()), 32'd6);
      check("rm.done", 32'(done), 32'h0);
      req     = 4'b1001;
      req_len = 16'h0000;
      rresetn = 1'b1;
      step();
      obs("rm.regrant", 4'b0001, 1'b1, 1'b0, 8'h00, 4'b0000);
      req = 4'b0000;
      step();
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/fifo_rd_burst_arbiter.md
Name: fifo_rd_burst_arbiter

Overview:
- Read-domain scheduler that shares one async-FIFO read port among NREQ consumers.
- Grants one consumer at a time, round-robin, for a burst of up to 2^LW words.
- Drives the FIFO pop strobe (rinc) only when the FIFO is not empty.
- Returns each popped word tagged with the owning consumer's index, plus a per-consumer burst-done pulse.

Parameters:
- NREQ, 4, number of consumers.
- DW, 8, FIFO data width.
- LW, 4, burst-length field width; encoded length = words-1, so 1..16 words.

Ports:
- clk  input  1  read-domain clock.
- rresetn  input  1  asynchronous active-low reset.
- req  input  NREQ  per-consumer burst request, level.
- req_len  input  NREQ*LW  per-consumer length-1; slice i = bits [i*LW +: LW].
- empty  input  1  FIFO empty flag from the read-pointer logic.
- fifo_rdata  input  DW  FIFO read data at the current read address; combinational, valid while empty=0.
- rinc  output  1  FIFO pop strobe.
- grant  output  NREQ  one-hot current owner; all-zero when idle.
- out_valid  output  1  registered data-valid pulse.
- out_data  output  DW  registered popped word.
- out_id  output  $clog2(NREQ)  owner index of out_data.
- done  output  NREQ  one-cycle pulse when that consumer's burst completes.

Behaviour:
- Interface: one clock (clk); reset rresetn is asynchronous, active-low.
- Reset values: grant=0, rinc=0, out_valid=0, out_data=0, out_id=0, done=0, state=IDLE, beat counter=0, rr pointer=NREQ-1 (consumer 0 has top priority first).
- States: IDLE, BURST.
- IDLE transition:
  - When any req bit is set, pick the first set bit searching upward (with wrap) from rr_ptr+1.
  - Latch the winner's index and req_len into the beat counter.
  - Register grant one-hot and move to BURST next cycle.
  - Grant therefore appears 1 cycle after req; no pop happens in IDLE.
- BURST pop:
  - rinc = ~empty, combinational from state and empty.
  - Beat accepted when rinc=1.
  - On accept: capture fifo_rdata into out_data and owner index into out_id; out_valid=1 next cycle. Read latency is 1 cycle.
- BURST stall:
  - empty=1 gives rinc=0 and no beat.
  - State, counter and grant hold indefinitely.
  - No timeout.
- BURST count and completion:
  - Counter decrements on each accepted beat.
  - Accept with counter==0 is the final beat. Next cycle: done[owner]=1, grant=0, rr_ptr=owner, state=IDLE.
  - done coincides with out_valid of the final word.
- Burst gap: at least one IDLE cycle between bursts, so a back-to-back grant to any consumer is 2 cycles after the final beat.
- Length bound: burst length is fixed at grant. Changes to req_len or req during BURST are ignored; dropping req does not abort.
- Round-robin fairness: the just-served consumer has lowest priority next arbitration. A sole requester may be re-granted.
- Length wrap: req_len = all-ones gives 16 words; all-zeros gives 1 word, so the grant and final beat can fall in the same BURST cycle.
- empty deasserting mid-burst: pop resumes the same cycle.
- out_valid is never asserted without a preceding accepted beat.
- Reset mid-burst: all outputs drop asynchronously to reset values. The FIFO is not popped further; the partial burst is lost and there is no done pulse.

Decomposition:
- Package fifo_arb_pkg: defaults for NREQ/DW/LW, the state encoding (IDLE=1'b0, BURST=1'b1), and the id-width function.
- Sub-module rr_pick: purely combinational round-robin picker.
  - Inputs: req vector and rr_ptr.
  - Outputs: one-hot winner and index.
  - Reused by the write-side arbiter.

Test Plan:
- Reset: hold rresetn=0 with req=4'b1111 -> grant=0, rinc=0, out_valid=0, done=0. After release, consumer 0 is granted at cycle 2.
- Single burst: req=4'b0100, req_len[2]=3, FIFO holds 0x10..0x13, empty=0 -> grant=4'b0100 from cycle 1. rinc high 4 cycles. out_data 0x10,0x11,0x12,0x13 with out_id=2. done[2] pulses with the 0x13 beat; grant=0 after.
- Round-robin: req=4'b1011 held, all req_len=0, FIFO always non-empty -> grant order 0,1,3,0,1,3. Each grant is one 1-word burst separated by one IDLE cycle.
- Stall: consumer 1 burst of 4 words; empty=1 after word 2 for 5 cycles -> rinc=0 during the stall, grant held, no out_valid. Words 3-4 delivered after empty clears; done[1] only after word 4.
- Max length and wrap: req_len[3]=4'hF -> exactly 16 pops. Counter wraps cleanly; done[3] on the 16th word; no 17th rinc.
- Reset mid-burst: assert rresetn=0 after word 2 of an 8-word burst -> rinc/grant drop the same cycle (async). No done pulse; after release, arbitration restarts with consumer 0 priority.
